fifo_axis_drain: RTL and testbench
==================================

# fifo_axis_drain

Downstream consumer of the synchronous trace FIFO. Drains buffered words through the FIFO's read port (`rd_en`, registered `rd_data`, `empty`, `counter`). Emits them as fixed-length AXI4-Stream packets toward the DMA engine, with `tlast` on the final beat of each packet. A flush request ends the stream early by sending a short packet of whatever is currently buffered.

## Interface
- `DATA_WIDTH`, 32: width of a FIFO word and of `m_axis_tdata`.
- `FIFO_DEPTH`, 8: depth of the upstream FIFO (power of 2); sets `fifo_counter` width to $clog2(FIFO_DEPTH)+1.
- `PACKET_LEN`, 8: beats per full packet; 1 ≤ PACKET_LEN ≤ FIFO_DEPTH.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `fifo_rd_en`  out  1  read strobe to FIFO; combinational.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO output; valid the cycle after an accepted read.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_counter`  in  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `flush`  in  1  single-cycle request to emit a short packet.
- `m_axis_tdata`  out  DATA_WIDTH  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  last beat of packet.
- `busy`  out  1  high while in STREAM.
- `packet_count`  out  32  packets completed (tlast handshakes); wraps modulo 2^32.

## Operation
- **States.** IDLE and STREAM.
- **IDLE.**
  - If `fifo_counter >= PACKET_LEN`: load `reads_left = PACKET_LEN`, go to STREAM.
  - Else if `flush_pending` and `fifo_counter > 0`: load `reads_left = fifo_counter`, clear `flush_pending`, go to STREAM.
  - Else if `flush_pending` and `fifo_counter == 0`: clear `flush_pending`, stay in IDLE.
- **flush_pending.** Set by `flush` in any state. Clearing happens only in IDLE, as above. A flush arriving in the same cycle it is cleared is kept (set wins).
- **STREAM.**
  - `fifo_rd_en = (reads_left != 0) && !fifo_empty && (occ + inflight - pop) < 2`.
    - `occ`: 0..2 entries in the internal output buffer.
    - `inflight`: registered copy of the previous cycle's `fifo_rd_en`.
    - `pop`: `m_axis_tvalid && m_axis_tready`.
  - Each read decrements `reads_left`. The read issued at `reads_left == 1` is tagged last.
  - The cycle after a read, `fifo_rd_data` and its last tag are pushed into the 2-entry output buffer.
  - STREAM returns to IDLE on the handshake of the beat tagged last. `packet_count` increments in that same cycle.
- **Output buffer.** 2-entry FIFO holding {data, last}.
  - `m_axis_tvalid = occ != 0`.
  - `m_axis_tdata` and `m_axis_tlast` come from the head entry.
  - Push and pop in the same cycle are both honoured.
  - The buffer never overflows; the `rd_en` gating guarantees this.
- **Reading when empty.** The block never reads an empty FIFO. The upstream FIFO's empty-read/write bypass is never exercised.
- **Reset.** Resets mid-operation discard buffered beats and in-flight reads, and return to IDLE. The FIFO shares the reset.

## Timing
- **Reset values.**
  - `fifo_rd_en` 0, `m_axis_tvalid` 0, `m_axis_tlast` 0, `m_axis_tdata` 0, `busy` 0, `packet_count` 0.
  - Internal: `occ` 0, `inflight` 0, `reads_left` 0, `flush_pending` 0, state IDLE.
- **Cycle T:** IDLE sees the start condition.
- **T+1:** STREAM; first `fifo_rd_en`.
- **T+2:** first `m_axis_tvalid`.
- **Throughput.** With `m_axis_tready` held high, one beat per cycle. A packet of N beats occupies cycles T+2..T+N+1.
- **Between packets.** After the tlast handshake at cycle L, state is IDLE at L+1. With data ready, the next packet's first beat is valid at L+3. `tvalid` is low for exactly 2 cycles.
- **AXI stability.** While `tvalid && !tready`, `tdata` and `tlast` are held stable, and `tvalid` is not withdrawn.
- **Outstanding beats.** `occ + inflight` never exceeds 2.

## Test plan
- **Reset.** Hold `rst` 3 cycles, with the FIFO pre-loaded and `tready=1` -> all outputs at their reset values. No `fifo_rd_en` until one cycle after `rst` falls.
- **Full packet.** `PACKET_LEN=4`. Write 0xA0..0xA3, `tready=1` -> beats A0, A1, A2, A3 on consecutive cycles, `tlast` only on A3. `fifo_rd_en` high exactly 4 cycles. `packet_count=1`.
- **Backpressure.** 4 items, `tready` pattern 1,0,0,1,0,1,1 ->
  - order preserved;
  - `tdata` stable during stalls;
  - `occ + inflight ≤ 2` every cycle;
  - no read while `fifo_empty`.
- **Flush.**
  - 3 items, `PACKET_LEN=4`, pulse `flush` -> 3 beats, `tlast` on the third, `packet_count` +1.
  - `flush` with the FIFO empty -> no beats, `flush_pending` cleared next cycle.
- **Back-to-back.** 8 items, `PACKET_LEN=4`, `tready=1` -> two packets, `tvalid` low exactly 2 cycles between them, `packet_count=2`.
- **Reset mid-packet.** Assert `rst` after beat 2 of 4 -> next cycle `tvalid=0`, `busy=0`, `packet_count` unchanged at 0 from reset. A fresh packet after refill starts from its first word.

Source files
------------

// File: rtl/fifo_axis_drain_if.sv
// Bus bundle between the trace-FIFO drain and its neighbours: the upstream FIFO
// read port plus the outgoing AXI4-Stream master channel.
interface fifo_axis_drain_if #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // upstream FIFO read port
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty;
   logic [CW-1:0]         fifo_counter;

   // AXI4-Stream toward the DMA engine
   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;

   modport master (
      output fifo_rd_en,
      input  fifo_rd_data,
      input  fifo_empty,
      input  fifo_counter,
      output m_axis_tdata,
      output m_axis_tvalid,
      output m_axis_tlast,
      input  m_axis_tready
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_rd_data,
      output fifo_empty,
      output fifo_counter,
      input  m_axis_tdata,
      input  m_axis_tvalid,
      input  m_axis_tlast,
      output m_axis_tready
   );
endinterface

// File: rtl/fifo_axis_drain.sv
// Drains the trace FIFO into fixed-length AXI4-Stream packets; a flush request
// sends whatever is buffered as one short packet.
module fifo_axis_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int PACKET_LEN = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   fifo_axis_drain_if.master     bus,
   input  logic                  flush,
   output logic                  busy,
   output logic [31:0]           packet_count
);
   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] PKT_LEN = CW'(PACKET_LEN);

   typedef enum logic {IDLE, STREAM} state_t;

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   state_t        state, state_n;
   logic [CW-1:0] reads_left, reads_left_n;
   logic          flush_pending, flush_pending_n, flush_clear;
   logic          inflight, inflight_last;
   logic [1:0]    occ;
   logic          rd_ptr, wr_ptr;
   beat_t         buf_mem [2];

   beat_t         incoming, head;
   logic [1:0]    visible;
   logic [2:0]    after_pop;
   logic          rd_en, pop, last_pop, tvalid;

   // The word returning from the FIFO counts as buffered in the cycle it lands,
   // so the stream sees it one cycle earlier than a stored copy would allow.
   // The read gate keeps occ <= 1 whenever a read is in flight.
   always_comb begin
      incoming = '{last: inflight_last, data: bus.fifo_rd_data};
      head     = (occ != 2'd0) ? buf_mem[rd_ptr] : incoming;
      visible  = occ + {1'b0, inflight};
   end

   assign tvalid   = (visible != 2'd0);
   assign pop      = tvalid && bus.m_axis_tready;
   assign last_pop = pop && head.last;

   assign bus.m_axis_tvalid = tvalid;
   assign bus.m_axis_tdata  = tvalid ? head.data : '0;
   assign bus.m_axis_tlast  = tvalid && head.last;
   assign bus.fifo_rd_en    = rd_en;
   assign busy              = (state == STREAM);

   // NOTE: every variable driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_n      = state;
      reads_left_n = reads_left;
      flush_clear  = 1'b0;
      rd_en        = 1'b0;
      after_pop    = {1'b0, visible} - {2'b00, pop};

      case (state)
         IDLE: begin
            if (bus.fifo_counter >= PKT_LEN) begin
               reads_left_n = PKT_LEN;
               state_n      = STREAM;
            end else if (flush_pending && bus.fifo_counter != '0) begin
               reads_left_n = bus.fifo_counter;
               flush_clear  = 1'b1;
               state_n      = STREAM;
            end else if (flush_pending) begin
               flush_clear  = 1'b1;
            end
         end
         STREAM: begin
            rd_en = !rst && (reads_left != '0) && !bus.fifo_empty && (after_pop < 3'd2);
            if (rd_en) reads_left_n = reads_left - CW'(1);
            if (last_pop) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // A flush landing in the cycle the pending flag is consumed survives.
      flush_pending_n = (flush_pending && !flush_clear) || flush;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         reads_left    <= '0;
         flush_pending <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         occ           <= 2'd0;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         packet_count  <= 32'd0;
      end else begin
         state         <= state_n;
         reads_left    <= reads_left_n;
         flush_pending <= flush_pending_n;
         inflight      <= rd_en;
         inflight_last <= rd_en && (reads_left == CW'(1));
         occ           <= after_pop[1:0];
         if (inflight) wr_ptr <= ~wr_ptr;
         if (pop)      rd_ptr <= ~rd_ptr;
         if (last_pop) packet_count <= packet_count + 32'd1;
      end
   end

   // NOTE: buffer storage carries no reset; occ and the pointers are reset and
   // tdata/tlast are masked by tvalid, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (inflight) buf_mem[wr_ptr] <= incoming;
   end
endmodule

// File: tb/tb_fifo_axis_drain.sv
// Self-checking bench for fifo_axis_drain: models the upstream FIFO and keeps a
// packet-level scoreboard of the beats the stream must carry.
module tb_fifo_axis_drain;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int PLEN  = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst, fifo_rst, flush, busy, wr_en;
   logic [DW-1:0] wr_data;
   logic [31:0]   packet_count;

   always #5 clk = ~clk;

   fifo_axis_drain_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   fifo_axis_drain #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PACKET_LEN(PLEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .flush        (flush),
      .busy         (busy),
      .packet_count (packet_count)
   );

   // upstream FIFO: registered read data, counter and empty flag
   logic [DW-1:0] fq [$];
   always @(posedge clk) begin
      if (fifo_rst) begin
         fq.delete();
         bus.fifo_rd_data <= '0;
         bus.fifo_counter <= '0;
         bus.fifo_empty   <= 1'b1;
      end else begin
         if (bus.fifo_rd_en && fq.size() > 0) bus.fifo_rd_data <= fq.pop_front();
         if (wr_en) fq.push_back(wr_data);
         bus.fifo_counter <= CW'(fq.size());
         bus.fifo_empty   <= (fq.size() == 0);
      end
   end

   int            tests = 0, fails = 0;
   int            cyc = 0, beats_seen = 0, reads_total = 0, pops_total = 0;
   logic [DW-1:0] pend [$];
   logic [DW-1:0] exp_data [$];
   logic          exp_last [$];
   int            beat_cyc [$];
   logic          prev_stall = 1'b0, prev_last;
   logic [DW-1:0] prev_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   always @(posedge clk) cyc++;

   // stream monitor: scoreboard, stall stability, outstanding bound, no empty reads
   always @(negedge clk) begin
      if (rst) begin
         reads_total = 0;
         pops_total  = 0;
         prev_stall  = 1'b0;
      end else begin
         if (bus.fifo_rd_en === 1'b1) begin
            check("rd_while_empty", bus.fifo_empty, 0);
            reads_total++;
         end
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            pops_total++;
            beats_seen++;
            beat_cyc.push_back(cyc);
            check("beat_expected", exp_data.size() != 0, 1);
            if (exp_data.size() != 0) begin
               check("tdata", bus.m_axis_tdata, exp_data.pop_front());
               check("tlast", bus.m_axis_tlast, exp_last.pop_front());
            end
         end
         check("outstanding_le2", (reads_total - pops_total) <= 2, 1);
         if (prev_stall) begin
            check("stall_tvalid", bus.m_axis_tvalid, 1);
            check("stall_tdata", bus.m_axis_tdata, prev_data);
            check("stall_tlast", bus.m_axis_tlast, prev_last);
         end
         prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
         prev_data  = bus.m_axis_tdata;
         prev_last  = bus.m_axis_tlast;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      pend.push_back(d);
      step();
      wr_en   = 1'b0;
   endtask

   task automatic write_random(input int n);
      for (int i = 0; i < n; i++) write_word($urandom());
   endtask

   // the next n written words form one packet, tlast on its final beat
   task automatic expect_packet(input int n);
      for (int i = 0; i < n; i++) begin
         exp_data.push_back(pend.pop_front());
         exp_last.push_back(i == n - 1);
      end
   endtask

   task automatic wait_beats(input string tag, input int target, input int budget);
      int k = 0;
      while (beats_seen < target && k < budget) begin
         step();
         k++;
      end
      check(tag, beats_seen >= target, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c_t, rd_start, base;

      rst = 1'b1; fifo_rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
      bus.m_axis_tready = 1'b1;
      step(); step();

      // reset held with a pre-loaded FIFO and tready high
      fifo_rst = 1'b0;
      for (int i = 0; i < PLEN; i++) write_word(32'hA0 + i);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_rd_en", bus.fifo_rd_en, 0);
         check("rst_tvalid", bus.m_axis_tvalid, 0);
         check("rst_tlast", bus.m_axis_tlast, 0);
         check("rst_tdata", bus.m_axis_tdata, 0);
         check("rst_busy", busy, 0);
         check("rst_pkt_cnt", packet_count, 0);
      end

      // full packet A0..A3 with tready high
      expect_packet(PLEN);
      beat_cyc.delete();
      rst = 1'b0;
      c_t = cyc;
      rd_start = 0;
      check("rd_en_at_T", bus.fifo_rd_en, 0);
      step();
      check("rd_en_at_T1", bus.fifo_rd_en, 1);
      check("busy_at_T1", busy, 1);
      wait_beats("full_pkt_timeout", 4, 20);
      check("full_first_beat_cyc", beat_cyc[0], c_t + 2);
      check("full_last_beat_cyc", beat_cyc[3], c_t + 5);
      check("full_rd_en_cycles", reads_total - rd_start, 4);
      check("full_pkt_cnt", packet_count, 1);
      check("full_busy_done", busy, 0);

      // backpressure with tready pattern 1,0,0,1,0,1,1
      bus.m_axis_tready = 1'b0;
      write_random(4);
      expect_packet(4);
      begin
         int k = 0;
         while (!bus.m_axis_tvalid && k < 20) begin step(); k++; end
         check("bp_valid_timeout", bus.m_axis_tvalid, 1);
      end
      begin
         logic [6:0] pat = 7'b1101001;
         for (int i = 0; i < 7; i++) begin
            bus.m_axis_tready = pat[i];
            step();
         end
      end
      bus.m_axis_tready = 1'b1;
      wait_beats("bp_timeout", 8, 20);
      check("bp_pkt_cnt", packet_count, 2);

      // flush with 3 buffered words
      write_random(3);
      for (int i = 0; i < 3; i++) begin
         step();
         check("short_no_start", bus.m_axis_tvalid, 0);
      end
      expect_packet(3);
      flush = 1'b1; step(); flush = 1'b0;
      wait_beats("flush_timeout", 11, 20);
      check("flush_pkt_cnt", packet_count, 3);

      // flush with the FIFO empty must leave nothing pending
      flush = 1'b1; step(); flush = 1'b0;
      step();
      check("flush_empty_busy", busy, 0);
      write_random(3);
      for (int i = 0; i < 4; i++) step();
      check("flush_empty_idle", busy, 0);
      check("flush_empty_tvalid", bus.m_axis_tvalid, 0);
      check("flush_empty_cnt", packet_count, 3);
      write_random(1);
      expect_packet(4);
      wait_beats("refill_timeout", 15, 20);
      check("refill_pkt_cnt", packet_count, 4);

      // back-to-back packets from 8 buffered words
      bus.m_axis_tready = 1'b0;
      write_random(8);
      expect_packet(4);
      expect_packet(4);
      step();
      beat_cyc.delete();
      bus.m_axis_tready = 1'b1;
      wait_beats("b2b_timeout", 23, 40);
      check("b2b_pkt1_span", beat_cyc[3] - beat_cyc[0], 3);
      check("b2b_gap", beat_cyc[4] - beat_cyc[3], 3);
      check("b2b_pkt2_span", beat_cyc[7] - beat_cyc[4], 3);
      check("b2b_pkt_cnt", packet_count, 6);

      // reset after beat 2 of 4, then a fresh packet
      write_random(4);
      expect_packet(4);
      base = beats_seen;
      begin
         int k = 0;
         while (beats_seen < base + 2 && k < 20) begin step(); k++; end
         check("mid_rst_reach", beats_seen, base + 2);
      end
      rst = 1'b1; fifo_rst = 1'b1; bus.m_axis_tready = 1'b0;
      step();
      rst = 1'b0; fifo_rst = 1'b0;
      check("mid_rst_tvalid", bus.m_axis_tvalid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pkt_cnt", packet_count, 0);
      check("mid_rst_rd_en", bus.fifo_rd_en, 0);
      exp_data.delete();
      exp_last.delete();
      pend.delete();
      bus.m_axis_tready = 1'b1;
      base = beats_seen;
      write_random(4);
      expect_packet(4);
      wait_beats("post_rst_timeout", base + 4, 20);
      check("post_rst_pkt_cnt", packet_count, 1);
      check("post_rst_drained", exp_data.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
